// File: rtl/instr_mem_server_if.sv
// Instruction-fetch / program-load bus between the board loader plus the
// processor (master) and the program store (slave).
//   load_start/load_valid/load_data/load_last : loader -> store
//   load_ready/load_count                     : store  -> loader
//   fetch_address                             : processor pc -> store
//   instruction/cpu_reset/fault               : store  -> processor
interface instr_mem_server_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [5:0]        load_count;
  logic [ADDR_W-1:0] fetch_address;
  logic [DATA_W-1:0] instruction;
  logic              cpu_reset;
  logic              fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_address,
    input  load_ready, load_count, instruction, cpu_reset, fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_address,
    output load_ready, load_count, instruction, cpu_reset, fault
  );
endinterface

// File: rtl/instr_mem_server.sv
// Program store serving the processor's instruction fetch. Holds the core
// in reset while a program is streamed in byte-serially, then answers
// fetches with a registered instruction (1-clock latency).
// Ports:
//   clock  : system clock, all state on posedge
//   reset  : synchronous, active-high; clears state and the whole store
//   bus    : slave side of instr_mem_server_if (load port + fetch port)
module instr_mem_server #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clock,
  input  logic          reset,
  instr_mem_server_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              load_ready_q;
  logic              cpu_reset_q;
  logic              fault_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              accept;
  logic              we;
  logic              in_range;

  // load_ready is already a decode of LOAD, so it alone qualifies a byte.
  assign accept   = bus.load_valid && load_ready_q;
  assign in_range = {1'b0, bus.fetch_address} < (ADDR_W+1)'(DEPTH);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      LOAD: begin
        // Restart beats any byte (including a last one) in the same cycle.
        if (bus.load_start) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
        end else if (accept) begin
          we = 1'b1;
          if (wr_ptr_q != AW'(DEPTH-1)) wr_ptr_d = wr_ptr_q + 1'b1;
          if (cnt_q != 6'(DEPTH))       cnt_d    = cnt_q + 6'd1;
          if (bus.load_last || wr_ptr_q == AW'(DEPTH-1)) state_d = RUN;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      // Registered decodes of the next state so they track state_q exactly.
      load_ready_q <= (state_d == LOAD);
      cpu_reset_q  <= (state_d != RUN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wr_ptr_q] <= bus.load_data;
    end
  end

  // Fetch only answers in RUN; out-of-range pcs read as zero and latch fault.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      fault_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (in_range) begin
        instr_q <= mem_q[bus.fetch_address[AW-1:0]];
      end else begin
        instr_q <= '0;
        fault_q <= 1'b1;
      end
    end else begin
      instr_q <= '0;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.load_count  = cnt_q;
  assign bus.instruction = instr_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_instr_mem_server.sv
module tb_instr_mem_server;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  instr_mem_server_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  instr_mem_server #(.DEPTH(32), .ADDR_W(8), .DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.fetch_address = a;
    tick();
    chk(tag, 32'(bus.instruction), 32'(exp));
  endtask

  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  initial begin
    bus.load_start    = 1'b0;
    bus.load_valid    = 1'b0;
    bus.load_data     = '0;
    bus.load_last     = 1'b0;
    bus.fetch_address = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state, fetch ignored outside RUN
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_ready",     32'(bus.load_ready), 32'd0);
    chk("rst_fault",     32'(bus.fault), 32'd0);
    chk("rst_count",     32'(bus.load_count), 32'd0);
    for (int a = 0; a < 4; a++) fetch(8'(a), 8'h00, "idle_fetch");
    chk("idle_fault",    32'(bus.fault), 32'd0);

    // 2: three-byte load
    start();
    chk("t2_ready",      32'(bus.load_ready), 32'd1);
    chk("t2_cpu_reset",  32'(bus.cpu_reset), 32'd1);
    send(8'h1B, 1'b0);
    send(8'h52, 1'b0);
    send(8'h93, 1'b1);
    chk("t2_count",      32'(bus.load_count), 32'd3);
    chk("t2_run_cpu",    32'(bus.cpu_reset), 32'd0);
    chk("t2_run_ready",  32'(bus.load_ready), 32'd0);
    fetch(8'd1, 8'h52, "t2_f1");
    fetch(8'd0, 8'h1B, "t2_f0");
    fetch(8'd2, 8'h93, "t2_f2");
    fetch(8'd3, 8'h00, "t2_f3");

    // 3: fill the store without load_last
    start();
    chk("t3_count0",     32'(bus.load_count), 32'd0);
    chk("t3_cpu_reset",  32'(bus.cpu_reset), 32'd1);
    for (int i = 0; i < 32; i++) send(8'(i), 1'b0);
    chk("t3_count32",    32'(bus.load_count), 32'd32);
    chk("t3_run_cpu",    32'(bus.cpu_reset), 32'd0);
    send(8'hEE, 1'b0);
    chk("t3_ignored",    32'(bus.load_count), 32'd32);
    fetch(8'd31, 8'h1F, "t3_f31");
    fetch(8'd1,  8'h01, "t3_f1");
    fetch(8'd5,  8'h05, "t3_f5");
    fetch(8'd0,  8'h00, "t3_f0");

    // 4: out-of-range fetch is sticky
    chk("t4_fault_pre",  32'(bus.fault), 32'd0);
    fetch(8'd40, 8'h00, "t4_f40");
    chk("t4_fault",      32'(bus.fault), 32'd1);
    fetch(8'd0, 8'h00, "t4_f0");
    fetch(8'd3, 8'h03, "t4_f3");
    chk("t4_fault_kept", 32'(bus.fault), 32'd1);

    // 5: gapped load with restart after two bytes
    start();
    chk("t5_fault_kept", 32'(bus.fault), 32'd1);
    send(8'hAA, 1'b0);
    tick();
    send(8'hBB, 1'b0);
    chk("t5_count2",     32'(bus.load_count), 32'd2);
    bus.load_start = 1'b1;
    send(8'hCC, 1'b1);
    bus.load_start = 1'b0;
    chk("t5_restart",    32'(bus.load_count), 32'd0);
    chk("t5_still_load", 32'(bus.load_ready), 32'd1);
    tick();
    send(8'hDD, 1'b0);
    tick();
    send(8'hEE, 1'b1);
    chk("t5_count",      32'(bus.load_count), 32'd2);
    fetch(8'd0, 8'hDD, "t5_f0");
    fetch(8'd1, 8'hEE, "t5_f1");
    fetch(8'd2, 8'h02, "t5_f2");

    // 6: reset mid-load clears everything
    start();
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
    chk("t6_count5",     32'(bus.load_count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_count",      32'(bus.load_count), 32'd0);
    chk("t6_cpu_reset",  32'(bus.cpu_reset), 32'd1);
    chk("t6_ready",      32'(bus.load_ready), 32'd0);
    chk("t6_fault",      32'(bus.fault), 32'd0);
    start();
    send(8'h77, 1'b1);
    chk("t6_count1",     32'(bus.load_count), 32'd1);
    fetch(8'd2, 8'h00, "t6_f2");
    fetch(8'd0, 8'h77, "t6_f0");
    fetch(8'd1, 8'h00, "t6_f1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
